// File: rtl/fetch_bundle_fifo.sv
// Fetch bundle queue: stores whole bundles, but each lane of the head can be consumed independently.
// Latency is 1 cycle from push to head, with no fall-through. accept_o reflects registered fullness only.
module fetch_bundle_fifo #(
    parameter int LANES      = 2,
    parameter int DEPTH      = 4,
    parameter int OPC_INFO_W = 12,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int COUNT_W   = ADDR_W + 1,
    localparam int OFS_W     = $clog2(LANES * 4)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [31:0]                   pc_in_i,
    input  logic [LANES-1:0]              pred_in_i,
    input  logic [LANES*32-1:0]           data_in_i,
    input  logic [LANES*OPC_INFO_W-1:0]   info_in_i,
    output logic                          accept_o,
    output logic [LANES-1:0]              valid_o,
    output logic [LANES*32-1:0]           pc_o,
    output logic [LANES*32-1:0]           data_o,
    output logic [LANES*OPC_INFO_W-1:0]   info_o,
    input  logic [LANES-1:0]              pop_i,
    output logic [COUNT_W-1:0]            level_o
);

    localparam logic [31:0] OFS_MASK = 32'(LANES * 4 - 1);

    logic [ADDR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0]          count_q, count_d;
    logic [LANES-1:0]            vld_q  [DEPTH];
    logic [31:0]                 pc_q   [DEPTH];
    logic [LANES*32-1:0]         data_q [DEPTH];
    logic [LANES*OPC_INFO_W-1:0] info_q [DEPTH];

    logic                        not_empty, do_push, do_retire;
    logic [LANES-1:0]            head_vld, pop_eff, head_vld_d, in_vld;
    logic [31:0]                 first_lane;
    logic                        blocked;

    assign not_empty  = (count_q != '0);
    assign accept_o   = (count_q != COUNT_W'(DEPTH));
    assign do_push    = push_i & accept_o & ~flush_i;
    assign head_vld   = vld_q[rd_ptr_q];
    assign valid_o    = not_empty ? head_vld : '0;
    assign pop_eff    = pop_i & valid_o;
    assign head_vld_d = head_vld & ~pop_eff;
    assign do_retire  = not_empty & ~flush_i & (head_vld_d == '0);
    assign data_o     = data_q[rd_ptr_q];
    assign info_o     = info_q[rd_ptr_q];
    assign level_o    = count_q;

    // Lanes before the fetch offset and after the first predicted-taken lane are dead.
    always_comb begin
        in_vld     = '0;
        blocked    = 1'b0;
        first_lane = (pc_in_i >> 2) & OFS_MASK[31:2] ;
        for (int k = 0; k < LANES; k++) begin
            if (32'(k) >= first_lane && !blocked) begin
                in_vld[k] = 1'b1;
                if (pred_in_i[k]) blocked = 1'b1;
            end
        end
    end

    always_comb begin
        pc_o = '0;
        for (int k = 0; k < LANES; k++) begin
            pc_o[32*k +: 32] = (pc_q[rd_ptr_q] & ~OFS_MASK) | 32'(k * 4);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push)   wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (do_retire) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (do_push && !do_retire)      count_d = count_q + COUNT_W'(1);
            else if (!do_push && do_retire) count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= '0;
                pc_q[i]   <= '0;
                data_q[i] <= '0;
                info_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) vld_q[i] <= '0;
            end else begin
                // Head and tail slots differ whenever both are active (never empty and full at once).
                if (not_empty) vld_q[rd_ptr_q] <= head_vld_d;
                if (do_push) begin
                    vld_q[wr_ptr_q]  <= in_vld;
                    pc_q[wr_ptr_q]   <= pc_in_i;
                    data_q[wr_ptr_q] <= data_in_i;
                    info_q[wr_ptr_q] <= info_in_i;
                end
            end
        end
    end

endmodule
